// File: rtl/elevator_ctrl_nfloor.sv
// rtl/elevator_ctrl_nfloor.sv - N-floor elevator controller with latched calls, SCAN service, timed travel and door
module elevator_ctrl_nfloor #(
  parameter int NB_FLOORS     = 4,
  parameter int TRAVEL_CYCLES = 2,
  parameter int DOOR_CYCLES   = 3,
  parameter int ERRNO         = 0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NB_FLOORS-1:0] call_i,
  output logic                 open_o,
  output logic [NB_FLOORS-1:0] floor_o,
  output logic                 moving_o,
  output logic                 up_o,
  output logic [NB_FLOORS-1:0] pending_o
);

  localparam int TW = $clog2(TRAVEL_CYCLES + 1);
  localparam int DW = $clog2(DOOR_CYCLES + 1);
  localparam logic [TW-1:0]        TRAVEL_LAST = TW'(TRAVEL_CYCLES - 1);
  localparam logic [DW-1:0]        DOOR_LAST   = DW'(DOOR_CYCLES - 1);
  localparam logic [NB_FLOORS-1:0] FLOOR_0     = NB_FLOORS'(1);

  typedef enum logic [1:0] {S_IDLE, S_MOVING, S_DOOR_OPEN} state_t;

  state_t               r_state, w_next_state;
  logic [NB_FLOORS-1:0] r_floor, w_next_floor;
  logic [NB_FLOORS-1:0] r_pending, w_next_pending;
  logic                 r_up, w_next_up;
  logic [TW-1:0]        r_travel_cnt, w_next_travel_cnt;
  logic [DW-1:0]        r_door_cnt, w_next_door_cnt;

  // Floor masks relative to the current floor and to the neighbour in the travel direction.
  // Subtracting one from a one-hot floor yields all floors strictly below it.
  logic [NB_FLOORS-1:0] w_step_floor;
  logic [NB_FLOORS-1:0] w_below_cur, w_above_cur, w_below_step, w_above_step;
  logic                 w_req_here, w_req_ahead, w_req_behind;
  logic                 w_step_req, w_step_beyond, w_recall;

  assign w_step_floor  = r_up ? (r_floor << 1) : (r_floor >> 1);
  assign w_below_cur   = r_floor - FLOOR_0;
  assign w_above_cur   = ~(w_below_cur | r_floor);
  assign w_below_step  = w_step_floor - FLOOR_0;
  assign w_above_step  = ~(w_below_step | w_step_floor);

  assign w_req_here    = |(r_pending & r_floor);
  assign w_req_ahead   = |(r_pending & (r_up ? w_above_cur : w_below_cur));
  assign w_req_behind  = |(r_pending & (r_up ? w_below_cur : w_above_cur));
  assign w_step_req    = |(r_pending & w_step_floor);
  assign w_step_beyond = |(r_pending & (r_up ? w_above_step : w_below_step));
  // Nonzero ERRNO values select verification mutants; 1 disables the door re-open on a local call.
  assign w_recall      = (|(call_i & r_floor)) && (ERRNO != 1);

  // State register: all controller state, asynchronously returned to ground floor idle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state      <= S_IDLE;
      r_floor      <= FLOOR_0;
      r_pending    <= '0;
      r_up         <= 1'b1;
      r_travel_cnt <= '0;
      r_door_cnt   <= '0;
    end else begin
      r_state      <= w_next_state;
      r_floor      <= w_next_floor;
      r_pending    <= w_next_pending;
      r_up         <= w_next_up;
      r_travel_cnt <= w_next_travel_cnt;
      r_door_cnt   <= w_next_door_cnt;
    end
  end

  // Next-state logic: SCAN decision in idle, per-floor travel timer, restartable door timer, request latch.
  always_comb begin
    w_next_state      = r_state;
    w_next_floor      = r_floor;
    w_next_up         = r_up;
    w_next_travel_cnt = r_travel_cnt;
    w_next_door_cnt   = r_door_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_req_here) begin
          w_next_state    = S_DOOR_OPEN;
          w_next_door_cnt = '0;
        end else if (w_req_ahead) begin
          w_next_state      = S_MOVING;
          w_next_travel_cnt = '0;
        end else if (w_req_behind) begin
          w_next_up         = ~r_up;
          w_next_state      = S_MOVING;
          w_next_travel_cnt = '0;
        end
      end
      S_MOVING: begin
        if (r_travel_cnt == TRAVEL_LAST) begin
          w_next_floor      = w_step_floor;
          w_next_travel_cnt = '0;
          if (w_step_req || !w_step_beyond) w_next_state = S_IDLE;
        end else begin
          w_next_travel_cnt = r_travel_cnt + 1'b1;
        end
      end
      S_DOOR_OPEN: begin
        if (w_recall) begin
          w_next_door_cnt = '0;
        end else if (r_door_cnt == DOOR_LAST) begin
          w_next_state = S_IDLE;
        end else begin
          w_next_door_cnt = r_door_cnt + 1'b1;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
    // The current floor's request is served by an open door, so it is dropped on entry and never latched while open.
    w_next_pending = r_pending | call_i;
    if (r_state == S_DOOR_OPEN || w_next_state == S_DOOR_OPEN) begin
      w_next_pending = w_next_pending & ~r_floor;
    end
  end

  // Output decode: every output is a direct function of registered state.
  always_comb begin
    open_o    = (r_state == S_DOOR_OPEN);
    moving_o  = (r_state == S_MOVING);
    floor_o   = r_floor;
    up_o      = r_up;
    pending_o = r_pending;
  end

endmodule
